// File: rtl/logic_arb_2to1.sv
// Round-robin arbiter sharing one bitwise logic unit (OR/AND/XOR/ANDN) between two requesters.
// Result registered with 1-cycle latency; a held result without out_ready blocks all grants.
module logic_arb_2to1 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] inA0,
    input  logic [WIDTH-1:0] inB0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] inA1,
    input  logic [WIDTH-1:0] inB1,
    output logic             gnt1,
    output logic [WIDTH-1:0] Out,
    output logic             out_valid,
    output logic             out_id,
    input  logic             out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             prio;
    logic             can_accept;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] res;

    assign out_valid = (state == FULL);

    // Draining and refilling the output register may happen in the same cycle.
    always_comb begin
        state_nxt  = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        can_accept = (state == EMPTY) || out_ready;
        if (!rst && can_accept) begin
            if (req0 && req1) begin
                gnt0 = !prio;
                gnt1 = prio;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
        if (gnt0 || gnt1) begin
            state_nxt = FULL;
        end else if (state == FULL && out_ready) begin
            state_nxt = EMPTY;
        end
    end

    // Operand mux is steered by the grant, so an idle side's X never reaches Out.
    always_comb begin
        op_sel = gnt1 ? op1  : op0;
        a_sel  = gnt1 ? inA1 : inA0;
        b_sel  = gnt1 ? inB1 : inB0;
        res    = '0;
        case (op_sel)
            2'b00:   res = a_sel | b_sel;
            2'b01:   res = a_sel & b_sel;
            2'b10:   res = a_sel ^ b_sel;
            default: res = a_sel & ~b_sel;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            Out    <= '0;
            out_id <= 1'b0;
            prio   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (gnt0 || gnt1) begin
                Out    <= res;
                out_id <= gnt1;
                prio   <= gnt0;
            end
        end
    end

endmodule
